option_rom_spi_loader: RTL

Boot-time loader that fills the Option-ROM BAR window from a donor ROM image held in SPI flash. On `start` it issues a standard SPI READ (0x03) and streams the image out of flash. It packs bytes into little-endian DWORDs and drives them into the ROM window's BAR write port, one single-cycle write per DWORD. It validates the 0x55AA header and the header length byte, and reports progress, completion and errors to the host-side control/status registers.

---
 rtl/option_rom_spi_loader_pkg.sv | 29 ++
 rtl/option_rom_spi_loader_if.sv | 10 +
 rtl/option_rom_spi_loader_spi_shift_engine.sv | 69 ++++++
 rtl/option_rom_spi_loader.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/option_rom_spi_loader_pkg.sv
// Shared types and constants for the Option-ROM SPI loader.
package option_rom_pkg;

  typedef enum logic [2:0] {
    LS_IDLE  = 3'd0,
    LS_CMD   = 3'd1,
    LS_READ  = 3'd2,
    LS_HDR   = 3'd3,
    LS_WRITE = 3'd4,
    LS_DONE  = 3'd5,
    LS_ERROR = 3'd6
  } loader_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BAD_SIG  = 2'd1,
    ERR_ZERO_LEN = 2'd2
  } loader_err_e;

  localparam logic [7:0]  SPI_CMD_READ       = 8'h03;
  localparam logic [15:0] ROM_SIGNATURE      = 16'hAA55;
  localparam int unsigned ROM_LEN_UNIT_BYTES = 512;

  // Shifter holds the first-arriving byte in [31:24]; the ROM window wants it in [7:0].
  function automatic logic [31:0] pack_le(input logic [31:0] arrival);
    return {arrival[7:0], arrival[15:8], arrival[23:16], arrival[31:24]};
  endfunction

endpackage

// File: rtl/option_rom_spi_loader_if.sv
// BAR write port into the Option-ROM window.
interface option_rom_spi_loader_if;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [2:0]  wr_bar_index;

  modport master (output wr_addr, output wr_data, output wr_en, output wr_bar_index);
  modport slave  (input  wr_addr, input  wr_data, input  wr_en, input  wr_bar_index);
endinterface

// File: rtl/option_rom_spi_loader_spi_shift_engine.sv
// SPI mode-0 SCK divider and 32-bit shifter; `go` loads and starts a word,
// `last` marks the final clk of the 32nd bit.
module spi_shift_engine
  import option_rom_pkg::*;
#(
  parameter int unsigned SCK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  input  logic [31:0] tx_word,
  input  logic        miso,
  output logic        sck,
  output logic        mosi,
  output logic [31:0] rx_word,
  output logic        last
);

  localparam logic [15:0] DIV_RELOAD = 16'(SCK_DIV - 1);

  logic        active;
  logic [15:0] div_cnt;
  logic [4:0]  bit_cnt;
  logic [31:0] shreg;
  logic        tick;

  assign tick    = active && (div_cnt == 16'd0);
  assign last    = tick && sck && (bit_cnt == 5'd31);
  assign rx_word = shreg;

  // MISO is captured on the rise; the shifted register then supplies the next MOSI bit on the fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
    end else if (go) begin
      active  <= 1'b1;
      div_cnt <= DIV_RELOAD;
      bit_cnt <= '0;
      shreg   <= tx_word;
      sck     <= 1'b0;
      mosi    <= tx_word[31];
    end else if (active) begin
      if (div_cnt != 16'd0) begin
        div_cnt <= div_cnt - 16'd1;
      end else begin
        div_cnt <= DIV_RELOAD;
        if (!sck) begin
          sck   <= 1'b1;
          shreg <= {shreg[30:0], miso};
        end else begin
          sck <= 1'b0;
          if (bit_cnt == 5'd31) begin
            active <= 1'b0;
            mosi   <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
            mosi    <= shreg[31];
          end
        end
      end
    end
  end

endmodule

// File: rtl/option_rom_spi_loader.sv
// Streams a donor Option-ROM image out of SPI flash and writes it, DWORD by
// DWORD, into the ROM BAR window after validating the 0x55AA header.
module option_rom_spi_loader
  import option_rom_pkg::*;
#(
  parameter int unsigned ROM_SIZE        = 65536,
  parameter logic [2:0]  ROM_BAR_INDEX   = 3'd5,
  parameter logic [23:0] FLASH_BASE_ADDR = 24'h100000,
  parameter int unsigned SCK_DIV         = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  error_code,
  output logic        truncated,
  output logic [15:0] words_loaded,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso,
  option_rom_spi_loader_if.master bar
);

  localparam logic [2:0] S_IDLE  = LS_IDLE;
  localparam logic [2:0] S_CMD   = LS_CMD;
  localparam logic [2:0] S_READ  = LS_READ;
  localparam logic [2:0] S_HDR   = LS_HDR;
  localparam logic [2:0] S_WRITE = LS_WRITE;
  localparam logic [2:0] S_DONE  = LS_DONE;
  localparam logic [2:0] S_ERROR = LS_ERROR;

  localparam logic [15:0] CAP_WORDS = 16'(ROM_SIZE / 4);

  logic [2:0]  state;
  logic [31:0] word;
  logic [15:0] total_words;
  logic        go;
  logic        last;
  logic [31:0] tx_word;
  logic [31:0] rx_word;
  logic        idle_like;
  logic        accept;
  logic        final_word;
  logic [7:0]  hdr_len;
  logic [31:0] len_words;
  logic [31:0] len_bytes;

  assign idle_like  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign accept     = start && idle_like;
  assign final_word = (words_loaded + 16'd1) == total_words;

  // 32-bit length arithmetic: a 0xFF header byte is 130560 bytes.
  assign hdr_len   = word[23:16];
  assign len_words = {24'd0, hdr_len} << 7;
  assign len_bytes = {24'd0, hdr_len} * ROM_LEN_UNIT_BYTES;

  always_comb begin
    go      = 1'b0;
    tx_word = '0;
    if (accept) begin
      go      = 1'b1;
      tx_word = {SPI_CMD_READ, FLASH_BASE_ADDR};
    end else if (state == S_CMD && last) begin
      go = 1'b1;
    end else if (state == S_WRITE && !final_word) begin
      go = 1'b1;
    end
  end

  spi_shift_engine #(.SCK_DIV(SCK_DIV)) u_shift (
    .clk     (clk),
    .reset_n (reset_n),
    .go      (go),
    .tx_word (tx_word),
    .miso    (spi_miso),
    .sck     (spi_sck),
    .mosi    (spi_mosi),
    .rx_word (rx_word),
    .last    (last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      error_code   <= ERR_NONE;
      truncated    <= 1'b0;
      words_loaded <= '0;
      word         <= '0;
      total_words  <= '0;
      spi_cs_n     <= 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state        <= S_CMD;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            error_code   <= ERR_NONE;
            truncated    <= 1'b0;
            words_loaded <= '0;
            spi_cs_n     <= 1'b0;
          end
        end
        S_CMD: begin
          if (last) state <= S_READ;
        end
        S_READ: begin
          if (last) begin
            word  <= pack_le(rx_word);
            state <= (words_loaded == 16'd0) ? S_HDR : S_WRITE;
          end
        end
        S_HDR: begin
          if (word[15:0] != ROM_SIGNATURE || hdr_len == 8'd0) begin
            state      <= S_ERROR;
            busy       <= 1'b0;
            error      <= 1'b1;
            error_code <= (word[15:0] != ROM_SIGNATURE) ? ERR_BAD_SIG : ERR_ZERO_LEN;
            spi_cs_n   <= 1'b1;
          end else begin
            total_words <= (len_words > 32'(CAP_WORDS)) ? CAP_WORDS : len_words[15:0];
            truncated   <= len_bytes > ROM_SIZE;
            state       <= S_WRITE;
          end
        end
        S_WRITE: begin
          words_loaded <= words_loaded + 16'd1;
          if (final_word) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            spi_cs_n <= 1'b1;
          end else begin
            state <= S_READ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bar.wr_en        = (state == S_WRITE);
  assign bar.wr_addr      = {14'd0, words_loaded, 2'b00};
  assign bar.wr_data      = word;
  assign bar.wr_bar_index = (state == S_WRITE) ? ROM_BAR_INDEX : 3'd0;

endmodule
